// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read data memory.
// The CPU port has fixed priority; a starvation counter guarantees the debug port a slot.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       cpu_rvalid_q, cpu_rvalid_d;
  logic       dbg_rvalid_q, dbg_rvalid_d;

  function automatic logic [3:0] starve_next(input logic [3:0] cnt, input logic dreq,
                                             input logic dgnt, input logic cgnt);
    logic [3:0] nxt;
    nxt = cnt;
    if (!dreq || dgnt)
      nxt = 4'd0;
    else if (cgnt && (cnt != LIMIT))
      nxt = cnt + 4'd1;
    return nxt;
  endfunction

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      if (cpu_req && dbg_req) begin
        if (starve_q == LIMIT) dbg_gnt = 1'b1;
        else                   cpu_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  // With no grant the CPU inputs are still steered out, with the write suppressed.
  always_comb begin
    mem_addr     = cpu_addr;
    mem_wdata    = cpu_wdata;
    mem_write_en = 1'b0;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (dbg_gnt) begin
      mem_addr     = dbg_addr;
      mem_wdata    = dbg_wdata;
      mem_write_en = dbg_we;
    end else if (cpu_gnt) begin
      mem_write_en = cpu_we;
    end
  end

  always_comb begin
    starve_d     = starve_next(starve_q, dbg_req, dbg_gnt, cpu_gnt);
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    dbg_rvalid_d = dbg_gnt & ~dbg_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q     <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 synchronous-read memory.
module tb_dmem_arbiter;

  logic       clk, reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_write_en;
  logic [7:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data_out only updates on non-write cycles.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_wdata;
    else              mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h5A; cpu_wdata = 8'h3C;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    step();
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dbg_rvalid", dbg_rvalid, 0);
    step();
    reset = 1'b0;
    cpu_req = 1'b0;
    step();

    // CPU write 0x10 <= 0xA5, then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    #1;
    chk("wr_cpu_gnt", cpu_gnt, 1);
    chk("wr_mem_we", mem_write_en, 1);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdata", mem_wdata, 8'hA5);
    step();
    chk("wr_no_rvalid", cpu_rvalid, 0);
    cpu_we = 1'b0;
    #1;
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_mem_we", mem_write_en, 0);
    step();
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 8'hA5);
    chk("rd_dbg_rvalid", dbg_rvalid, 0);

    // Debug-only read of 0x10
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
    #1;
    chk("dbg_gnt", dbg_gnt, 1);
    chk("dbg_cpu_gnt", cpu_gnt, 0);
    chk("dbg_mem_addr", mem_addr, 8'h10);
    step();
    chk("dbg_rvalid", dbg_rvalid, 1);
    chk("dbg_rdata", dbg_rdata, 8'hA5);
    chk("dbg_cpu_rvalid", cpu_rvalid, 0);

    // Idle: CPU inputs steered out, write suppressed
    dbg_req = 1'b0;
    cpu_we = 1'b1; cpu_addr = 8'h77; cpu_wdata = 8'h99;
    #1;
    chk("idle_cpu_gnt", cpu_gnt, 0);
    chk("idle_dbg_gnt", dbg_gnt, 0);
    chk("idle_mem_we", mem_write_en, 0);
    chk("idle_mem_addr", mem_addr, 8'h77);
    chk("idle_mem_wdata", mem_wdata, 8'h99);
    step();
    chk("idle_dbg_rvalid", dbg_rvalid, 0);

    // Both requesting continuously: C,C,C,C,D repeating
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h30;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_cpu_gnt_%0d", i), cpu_gnt, (i % 5 == 4) ? 0 : 1);
      chk($sformatf("starve_dbg_gnt_%0d", i), dbg_gnt, (i % 5 == 4) ? 1 : 0);
      step();
      chk($sformatf("starve_dbg_rvalid_%0d", i), dbg_rvalid, (i % 5 == 4) ? 1 : 0);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();

    // Back-to-back mixed traffic
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h01; cpu_wdata = 8'h11;
    step();
    cpu_addr = 8'h02; cpu_wdata = 8'h22;
    step();
    cpu_we = 1'b0; cpu_addr = 8'h01;
    #1;
    chk("mix_rd1_gnt", cpu_gnt, 1);
    step();
    chk("mix_rd1_rvalid", cpu_rvalid, 1);
    chk("mix_rd1_rdata", cpu_rdata, 8'h11);
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h02; dbg_wdata = 8'h5C;
    #1;
    chk("mix_wr_dbg_gnt", dbg_gnt, 1);
    chk("mix_wr_mem_we", mem_write_en, 1);
    chk("mix_wr_mem_addr", mem_addr, 8'h02);
    step();
    chk("mix_wr_dbg_rvalid", dbg_rvalid, 0);
    chk("mix_wr_cpu_rvalid", cpu_rvalid, 0);
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h02;
    step();
    chk("mix_rd2_rvalid", cpu_rvalid, 1);
    chk("mix_rd2_rdata", cpu_rdata, 8'h5C);
    cpu_req = 1'b0;
    step();

    // Reset during a pending read, with the starvation count part-way up
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h30;
    step();
    step();
    chk("mr_pre_rvalid", cpu_rvalid, 1);
    chk("mr_pre_gnt", cpu_gnt, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_rvalid_cleared", cpu_rvalid, 0);
    chk("mr_gnt_forced", cpu_gnt, 0);
    chk("mr_mem_addr", mem_addr, 0);
    step();
    chk("mr_rvalid_after_edge", cpu_rvalid, 0);
    chk("mr_dbg_rvalid", dbg_rvalid, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("mr_cpu_gnt_%0d", i), cpu_gnt, (i == 4) ? 0 : 1);
      chk($sformatf("mr_dbg_gnt_%0d", i), dbg_gnt, (i == 4) ? 1 : 0);
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter placed in front of the single-port data memory (256x8, synchronous read, one-cycle read latency).
- Port 0 is the CPU load/store unit. Port 1 is the debug/loader path, which uploads and inspects data memory while the CPU runs.
- The CPU has fixed priority. A starvation counter guarantees the debug port a slot.
- The block steers address, write data and write enable to the memory, and routes the registered read data back to whichever requester issued the read.

Parameters:
- ADDR_W, 8, address width; matches data memory depth of 256.
- DATA_W, 8, data width.
- STARVE_LIMIT, 4, maximum consecutive CPU grants while the debug port waits; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  combinational; access issued to memory this cycle.
- cpu_rvalid  out  1  registered; cpu_rdata valid this cycle.
- cpu_rdata  out  DATA_W  read data to CPU.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request; same rules as CPU.
- dbg_gnt  out  1  combinational grant to debug port.
- dbg_rvalid  out  1  registered read-valid to debug port.
- dbg_rdata  out  DATA_W  read data to debug port.
- mem_write_en  out  1  to memory write_en.
- mem_addr  out  ADDR_W  to memory addr_in.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out.

Behaviour:
- Reset, asynchronous:
  - cpu_rvalid = dbg_rvalid = 0.
  - Starvation count = 0.
  - Owner-of-pending-read flags cleared.
  - While reset is high, both grants are forced to 0, mem_write_en = 0, and mem_addr = mem_wdata = 0.
- Grant rule (combinational, at most one grant per cycle):
  - Only CPU requesting: cpu_gnt.
  - Only debug requesting: dbg_gnt.
  - Both requesting: dbg_gnt if starve_cnt == STARVE_LIMIT, else cpu_gnt.
  - Neither requesting: no grant. mem_write_en = 0, and mem_addr/mem_wdata hold the CPU inputs.
- Muxing: mem_addr, mem_wdata and mem_write_en (= granted port's we) come from the granted port in the same cycle.
- Starvation counter, 4 bits, updated on the clock edge:
  - Increments, saturating at STARVE_LIMIT, on each cycle with cpu_gnt while dbg_req is high.
  - Clears on dbg_gnt or when dbg_req is low.
- Read pipeline:
  - A read granted in cycle N sets that port's rvalid for exactly cycle N+1.
  - The port's rdata equals mem_rdata in that cycle.
  - Writes never assert rvalid.
- Throughput:
  - One access per cycle, with back-to-back reads allowed.
  - A write issued in N+1 does not disturb the rdata delivered in N+1, because memory data_out only changes on reads.
- rdata outside rvalid is don't-care. Both rdata outputs wire to mem_rdata.
- Requester contract:
  - Inputs stay stable while req is high and gnt is low.
  - A requester may raise req again in the cycle after its gnt.
- Reset asserted mid-read: the pending rvalid is cleared immediately and never delivered.
- Memory addresses wrap naturally at 8 bits. The block performs no address checking.

Test Plan:
- Reset: hold reset, drive cpu_req=1 -> cpu_gnt=0, dbg_gnt=0, mem_write_en=0, both rvalid=0.
- CPU write then read: cpu write addr 0x10 data 0xA5, then read 0x10 -> gnt in each cycle; cpu_rvalid=1 one cycle after the read grant with cpu_rdata=0xA5; dbg_rvalid stays 0.
- Debug-only: dbg_req reads 0x10 -> dbg_gnt same cycle, dbg_rvalid next cycle with 0xA5.
- Starvation: both request continuously, STARVE_LIMIT=4 -> grant pattern C,C,C,C,D repeating. The debug port waits no more than 4 cycles.
- Back-to-back mixed: CPU reads 0x01 (data 0x11), debug writes 0x02 next cycle, CPU reads 0x02 -> cpu_rvalid with 0x11, then later with the new debug value.
- Reset mid-read: grant a CPU read, then assert reset before the next edge -> cpu_rvalid never pulses and starve_cnt returns to 0.
